// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_seq
// Purpose  : Sequential restoring unsigned divider. A start pulse captures a
//            dividend and divisor; one quotient bit is resolved per clock.
//            The quotient and remainder are published together with a
//            single-cycle done pulse. A zero divisor short-circuits to a
//            one-cycle result with the divide-by-zero flag set.
// Ports    : clk   - system clock, rising edge
//            rst   - synchronous active-high reset
//            start - request pulse, honoured only while busy=0
//            a     - dividend, captured on an accepted start
//            b     - divisor, captured on an accepted start
//            q     - quotient (all ones on divide-by-zero)
//            r     - remainder (the dividend on divide-by-zero)
//            busy  - high while a division is in flight
//            done  - one-cycle pulse, q/r/dz updated in this cycle
//            dz    - divide-by-zero flag of the most recent result
// Revision : 1.0 - initial release
// ============================================================================
module divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t state, state_nx;

  // quo starts as the dividend and is shifted out MSB-first while the
  // resolved quotient bits are shifted in at the LSB.
  logic [WIDTH-1:0] quo,     quo_nx;
  logic [WIDTH:0]   rem,     rem_nx;
  logic [WIDTH-1:0] divisor, divisor_nx;
  logic [CNT_W-1:0] count,   count_nx;

  logic [WIDTH-1:0] q_nx, r_nx;
  logic             busy_nx, done_nx, dz_nx;

  // One extra guard bit above the partial remainder so the sign of the
  // trial subtraction is always observable.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    fits    = ~trial[WIDTH+1];
  end

  always_comb begin
    state_nx   = state;
    quo_nx     = quo;
    rem_nx     = rem;
    divisor_nx = divisor;
    count_nx   = count;
    q_nx       = q;
    r_nx       = r;
    dz_nx      = dz;
    busy_nx    = busy;
    done_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          quo_nx     = a;
          divisor_nx = b;
          rem_nx     = '0;
          count_nx   = CNT_W'(WIDTH);
          busy_nx    = 1'b1;
          state_nx   = (b == '0) ? ZERO : CALC;
        end
      end

      CALC: begin
        rem_nx   = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
        quo_nx   = {quo[WIDTH-2:0], fits};
        count_nx = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          q_nx     = {quo[WIDTH-2:0], fits};
          r_nx     = rem_nx[WIDTH-1:0];
          dz_nx    = 1'b0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end

      ZERO: begin
        // quo was never shifted, so it still holds the captured dividend.
        q_nx     = '1;
        r_nx     = quo;
        dz_nx    = 1'b1;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      count   <= '0;
      q       <= '0;
      r       <= '0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      quo     <= quo_nx;
      rem     <= rem_nx;
      divisor <= divisor_nx;
      count   <= count_nx;
      q       <= q_nx;
      r       <= r_nx;
      dz      <= dz_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_seq
// Purpose  : Directed self-checking bench for divider_seq at WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dz;

  int checks = 0;
  int fails  = 0;

  divider_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  // Issue one start and wait (bounded) for done. lat counts edges from the
  // accepting edge to the edge that raised done. hs_ok clears if busy was low
  // before done, high in the done cycle, or done was already high right after
  // the accepting edge.
  task automatic run_div(input logic [3:0] ta, input logic [3:0] tb_v,
                         output int lat, output logic hs_ok);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    hs_ok = 1'b1;
    if (done !== 1'b0) hs_ok = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) hs_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({q, r, busy, done, dz} !== 11'd0) begin
      fails++;
      $display("FAIL reset_state: got q=%0d r=%0d busy=%b done=%b dz=%b, want all zero",
               q, r, busy, done, dz);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [3:0] va [7] = '{4'd10, 4'd4, 4'd6, 4'd13, 4'd3, 4'd15, 4'd15};
    logic [3:0] vb [7] = '{4'd2,  4'd2, 4'd2, 4'd4,  4'd7, 4'd1,  4'd15};
    logic [3:0] eq [7] = '{4'd5,  4'd2, 4'd3, 4'd3,  4'd0, 4'd15, 4'd1};
    logic [3:0] er [7] = '{4'd0,  4'd0, 4'd0, 4'd1,  4'd3, 4'd0,  4'd0};
    int   lat;
    logic hs;
    for (int i = 0; i < 7; i++) begin
      run_div(va[i], vb[i], lat, hs);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0 || lat != 4 || !hs) begin
        fails++;
        $display("FAIL basic_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d hs=%b, want q=%0d r=%0d dz=0 lat=4 hs=1",
                 va[i], vb[i], q, r, dz, lat, hs, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int   lat;
    logic hs;
    run_div(4'd9, 4'd0, lat, hs);
    checks++;
    if (q !== 4'hF || r !== 4'd9 || dz !== 1'b1 || lat != 1 || !hs) begin
      fails++;
      $display("FAIL div_zero: got q=%0d r=%0d dz=%b lat=%0d hs=%b, want q=15 r=9 dz=1 lat=1 hs=1",
               q, r, dz, lat, hs);
    end
    run_div(4'd8, 4'd3, lat, hs);
    checks++;
    if (q !== 4'd2 || r !== 4'd2 || dz !== 1'b0 || lat != 4 || !hs) begin
      fails++;
      $display("FAIL after_zero: got q=%0d r=%0d dz=%b lat=%0d, want q=2 r=2 dz=0 lat=4",
               q, r, dz, lat);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    int lat;
    // Start 10/3, then a stray 15/1 start two cycles in.
    @(negedge clk);
    a = 4'd10; b = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dones = 0;
    lat   = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin
        @(negedge clk); a = 4'd15; b = 4'd1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        lat = c;
      end
    end
    checks++;
    if (dones != 1 || lat != 4 || q !== 4'd3 || r !== 4'd1 || dz !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy_start: got dones=%0d lat=%0d q=%0d r=%0d dz=%b, want 1 4 3 1 0",
               dones, lat, q, r, dz);
    end
    // Now in the done cycle: a start here must be accepted.
    @(negedge clk); a = 4'd7; b = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle_start: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    dones = 0;
    lat   = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        if (lat == 0) lat = c;
      end
    end
    checks++;
    if (dones != 1 || lat != 4 || q !== 4'd3 || r !== 4'd1) begin
      fails++;
      $display("FAIL back_to_back: got dones=%0d lat=%0d q=%0d r=%0d, want 1 4 3 1",
               dones, lat, q, r);
    end
  endtask

  task automatic test_reset_mid;
    int   dones;
    int   lat;
    logic hs;
    @(negedge clk);
    a = 4'd14; b = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({q, r, busy, done, dz} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_state: got q=%0d r=%0d busy=%b done=%b dz=%b, want all zero",
               q, r, busy, done, dz);
    end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: got %0d active cycles after abort, want 0", dones);
    end
    run_div(4'd14, 4'd3, lat, hs);
    checks++;
    if (q !== 4'd4 || r !== 4'd2 || dz !== 1'b0 || lat != 4 || !hs) begin
      fails++;
      $display("FAIL reset_mid_retry: got q=%0d r=%0d dz=%b lat=%0d, want q=4 r=2 dz=0 lat=4",
               q, r, dz, lat);
    end
  endtask

  task automatic test_sweep;
    int   lat;
    logic hs;
    int   bad;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_div(4'(ia), 4'(ib), lat, hs);
        bad = 0;
        if (ib == 0) begin
          if (dz !== 1'b1 || q !== 4'hF || r !== 4'(ia) || lat != 1) bad = 1;
        end else begin
          if (dz !== 1'b0 || (int'(q) * ib + int'(r)) != ia || int'(r) >= ib || lat != 4)
            bad = 1;
        end
        if (!hs) bad = 1;
        checks++;
        if (bad != 0) begin
          fails++;
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d hs=%b",
                   ia, ib, q, r, dz, lat, hs);
        end
      end
    end
    // done must drop in the cycle after the final pulse.
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_single_cycle: got done=%b, want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Sequential restoring unsigned divider, the inverse datapath of the lab's sequential multiplier. Accepts a dividend and divisor on a start pulse and produces one quotient bit per clock. Presents the quotient and remainder with a one-cycle done pulse. Used to check multiplier products (p / b == a) and as a standalone arithmetic unit on the same clock domain.

Parameters:
WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..16)

Ports:
clk    input   1      system clock, all logic on rising edge
rst    input   1      synchronous active-high reset
start  input   1      request pulse; sampled only when busy=0
a      input   WIDTH  dividend, captured on accepted start
b      input   WIDTH  divisor, captured on accepted start
q      output  WIDTH  quotient
r      output  WIDTH  remainder
busy   output  1      high while a division is in progress
done   output  1      one-cycle pulse: q/r/dz valid and updated
dz     output  1      divide-by-zero flag for the most recent result

Behaviour:
- Reset: rst=1 at a rising edge forces state IDLE. q=0, r=0, busy=0, done=0, dz=0. Internal accumulator, divisor and bit counter are cleared. Reset takes priority over every other input.
- Reset mid-operation: the division is aborted, no done pulse is issued, and outputs take their reset values.
- FSM states:
  - IDLE: start=1 → latch a into the quotient/shift register, latch b into the divisor register, clear the partial remainder (WIDTH+1 bits), load the counter with WIDTH, busy←1.
    - If b==0 → state ZERO.
    - Otherwise → state CALC.
  - CALC: each cycle, shift {partial remainder, quotient} left by 1, then trial-subtract the divisor.
    - If the result is non-negative → keep the difference, set quotient LSB=1.
    - Otherwise → restore, set quotient LSB=0.
    - Decrement the counter. On the last iteration (counter==1): write q, r and dz=0, pulse done, busy←0, → IDLE.
  - ZERO: q←all ones, r←latched dividend, dz←1, pulse done, busy←0, → IDLE.
- Latency: start accepted at edge k.
  - Nonzero divisor: done=1 and q/r valid during the cycle following edge k+WIDTH (WIDTH cycles after acceptance).
  - Zero divisor: done follows edge k+1.
- busy is high from edge k until the edge that asserts done; it is low in the done cycle.
- start in the done cycle is accepted (state is IDLE). Back-to-back divisions therefore have a throughput of WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued, and a/b changes do not disturb the operation in flight.
- q, r and dz hold their last written values until the next completion or reset. They are not cleared on start.
- Arithmetic is unsigned. Invariant for b≠0: a == q*b + r and r < b. The partial remainder is WIDTH+1 bits internally, so the trial subtraction never overflows.
- done is registered and glitch-free; it is never high for two consecutive cycles.

Test Plan:
- rst 1 cycle, then start with a=10, b=2 (WIDTH=4) → busy high 4 cycles; done 4 cycles after the start edge with q=5, r=0, dz=0. Repeat for 4/2 → q=2 r=0 and 6/2 → q=3 r=0.
- a=13, b=4 → q=3, r=1. a=3, b=7 → q=0, r=3. a=15, b=1 → q=15, r=0. a=15, b=15 → q=1, r=0.
- a=9, b=0 → done one cycle after start; q=4'hF, r=9, dz=1. A following 8/3 → q=2, r=2, dz=0.
- Start 10/3, pulse start with a=15, b=1 two cycles later → second start ignored; done once with q=3, r=1. Start asserted again in the done cycle → accepted; next done arrives WIDTH cycles later.
- Start 14/3, assert rst at cycle 2 of CALC → no done pulse; q=0, r=0, busy=0. Then 14/3 → q=4, r=2.
- Exhaustive sweep, all a and b in 0..15 → for every b≠0, q*b+r==a and r<b; for b=0, dz=1. Exactly one done per start, and latency matches the Behaviour rules.
